// File: rtl/mod_n_counter_seq_if.sv
// Command channel for mod_n_counter_seq: a valid/ready handshake carrying modulus, direction and lap count.
// The master drives the command; the slave returns ready.
interface mod_n_counter_seq_if #(
    parameter int WIDTH = 4,
    parameter int LAPW  = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_mod;
    logic             cmd_dir;
    logic [LAPW-1:0]  cmd_laps;

    modport master (output cmd_valid, cmd_mod, cmd_dir, cmd_laps, input cmd_ready);
    modport slave  (input cmd_valid, cmd_mod, cmd_dir, cmd_laps, output cmd_ready);
endinterface

// File: rtl/mod_n_counter_seq.sv
// Command-driven mod-N up/down counter that runs for a given number of wraps, then pulses done.
// Latency: handshake -> load 1 cycle; final wrap at t0+1+M*L; done in the following cycle; ready again one cycle later.
// Backpressure: cmd_ready is high only in IDLE; illegal commands are consumed with an err pulse.
module mod_n_counter_seq #(
    parameter int WIDTH = 4,
    parameter int LAPW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    mod_n_counter_seq_if.slave cmd,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mod_r, mod_m1;
    logic             dir_r;
    logic [LAPW-1:0]  laps_left;
    logic             cmd_bad, at_wrap;
    logic             accept, reject, do_load, do_step;

    assign mod_m1        = mod_r - WIDTH'(1);
    assign at_wrap       = dir_r ? (count == mod_m1) : (count == '0);
    assign cmd_bad       = (cmd.cmd_mod < WIDTH'(2)) || (cmd.cmd_laps == '0);
    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state == LOAD) || (state == RUN);
    assign done          = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        do_load   = 1'b0;
        do_step   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    if (cmd_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    do_load   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // abort wins over pause and over a wrap landing on the same edge
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!pause) begin
                    do_step = 1'b1;
                    if (at_wrap && laps_left == LAPW'(1)) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            wrap      <= 1'b0;
            err       <= 1'b0;
            mod_r     <= '0;
            dir_r     <= 1'b0;
            laps_left <= '0;
        end else begin
            err  <= reject;
            wrap <= do_step && at_wrap;
            if (accept) begin
                mod_r     <= cmd.cmd_mod;
                dir_r     <= cmd.cmd_dir;
                laps_left <= cmd.cmd_laps;
            end
            if (do_load) begin
                count <= dir_r ? '0 : mod_m1;
            end else if (do_step) begin
                if (at_wrap) begin
                    count     <= dir_r ? '0 : mod_m1;
                    laps_left <= laps_left - LAPW'(1);
                end else begin
                    count <= dir_r ? count + WIDTH'(1) : count - WIDTH'(1);
                end
            end
        end
    end
endmodule
